// File: rtl/usbfs_serial_regs.sv
// usbfs_serial_regs: byte-command register bridge for the USB-serial core.
// The host sends a command byte (bit7 = write, bits[6:0] = address), optionally
// followed by a data byte. Reads return one response byte on the device-to-host stream.
module usbfs_serial_regs #(
  parameter int          N_REG          = 8,
  parameter logic [7:0]  ID_BYTE        = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 48000
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  output logic               o_hostToDev_ready,
  input  logic               i_hostToDev_valid,
  input  logic [7:0]         i_hostToDev_data,
  input  logic               i_devToHost_ready,
  output logic               o_devToHost_valid,
  output logic [7:0]         o_devToHost_data,
  input  logic [7:0]         i_status,
  output logic [8*N_REG-1:0] o_regs,
  output logic [N_REG-1:0]   o_wrStrobe
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WRDATA = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  localparam logic [6:0] ADDR_ID     = 7'h7F;
  localparam logic [6:0] ADDR_STATUS = 7'h7E;

  state_e                   state_q, state_d;
  logic [6:0]               addr_q, addr_d;
  logic [7:0]               resp_q, resp_d;
  logic [N_REG-1:0][7:0]    regs_q, regs_d;
  logic [N_REG-1:0]         strobe_q, strobe_d;

  logic                     ready_s;
  logic                     hs_in_s;
  logic                     expire_s;
  logic [7:0]               rd_val_s;

  // Upstream is stalled only while a response byte is waiting to leave.
  assign ready_s = (state_q != ST_RESP);
  assign hs_in_s = i_hostToDev_valid && ready_s;

  // Write-data timeout: counts WRDATA cycles without a data byte.
  if (TIMEOUT_CYCLES > 0) begin : g_tmo
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    assign expire_s = (state_q == ST_WRDATA) && !hs_in_s &&
                      (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));

    // Next count: advance while waiting for data, otherwise hold at zero so
    // every entry into WRDATA starts from a cleared counter.
    always_comb begin
      tmo_cnt_d = '0;
      if ((state_q == ST_WRDATA) && !hs_in_s && !expire_s) begin
        tmo_cnt_d = tmo_cnt_q + TW'(1);
      end else begin
        tmo_cnt_d = '0;
      end
    end

    // Timeout counter register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        tmo_cnt_q <= '0;
      end else begin
        tmo_cnt_q <= tmo_cnt_d;
      end
    end
  end else begin : g_no_tmo
    assign expire_s = 1'b0;
  end

  // Read mux evaluated on the command byte currently presented upstream.
  always_comb begin
    rd_val_s = 8'h00;
    if (i_hostToDev_data[6:0] == ADDR_ID) begin
      rd_val_s = ID_BYTE;
    end else if (i_hostToDev_data[6:0] == ADDR_STATUS) begin
      rd_val_s = i_status;
    end else begin
      for (int k = 0; k < N_REG; k++) begin
        rd_val_s = (i_hostToDev_data[6:0] == 7'(k)) ? regs_q[k] : rd_val_s;
      end
    end
  end

  // Command FSM: next state, address/response latching and register writes.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    resp_d   = resp_q;
    regs_d   = regs_q;
    strobe_d = '0;
    case (state_q)
      ST_IDLE: begin
        if (hs_in_s) begin
          if (i_hostToDev_data[7]) begin
            addr_d  = i_hostToDev_data[6:0];
            state_d = ST_WRDATA;
          end else begin
            resp_d  = rd_val_s;
            state_d = ST_RESP;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRDATA: begin
        if (hs_in_s) begin
          // Out-of-range addresses match no entry: byte consumed, nothing written.
          for (int k = 0; k < N_REG; k++) begin
            if (addr_q == 7'(k)) begin
              regs_d[k]   = i_hostToDev_data;
              strobe_d[k] = 1'b1;
            end else begin
              regs_d[k]   = regs_q[k];
              strobe_d[k] = 1'b0;
            end
          end
          state_d = ST_IDLE;
        end else if (expire_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WRDATA;
        end
      end
      ST_RESP: begin
        if (i_devToHost_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, address, response, register bank and strobe registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q  <= ST_IDLE;
      addr_q   <= 7'h00;
      resp_q   <= 8'h00;
      regs_q   <= '0;
      strobe_q <= '0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      resp_q   <= resp_d;
      regs_q   <= regs_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_hostToDev_ready = ready_s;
  assign o_devToHost_valid = (state_q == ST_RESP);
  assign o_devToHost_data  = resp_q;
  assign o_regs            = regs_q;
  assign o_wrStrobe        = strobe_q;

endmodule

// File: tb/tb_usbfs_serial_regs.sv
// Testbench for usbfs_serial_regs: directed command sequences, a transaction-level
// reference model, a per-cycle compare process and literal spot checks.
module tb_usbfs_serial_regs;

  localparam int NR  = 8;
  localparam int TMO = 16;

  logic          i_clk = 1'b0;
  logic          i_rst_n = 1'b1;
  logic          o_hostToDev_ready;
  logic          i_hostToDev_valid = 1'b0;
  logic [7:0]    i_hostToDev_data = 8'h00;
  logic          i_devToHost_ready = 1'b1;
  logic          o_devToHost_valid;
  logic [7:0]    o_devToHost_data;
  logic [7:0]    i_status = 8'h3C;
  logic [8*NR-1:0] o_regs;
  logic [NR-1:0] o_wrStrobe;

  int vectors = 0;
  int miscompares = 0;

  usbfs_serial_regs #(.N_REG(NR), .ID_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .o_hostToDev_ready(o_hostToDev_ready),
    .i_hostToDev_valid(i_hostToDev_valid), .i_hostToDev_data(i_hostToDev_data),
    .i_devToHost_ready(i_devToHost_ready),
    .o_devToHost_valid(o_devToHost_valid), .o_devToHost_data(o_devToHost_data),
    .i_status(i_status), .o_regs(o_regs), .o_wrStrobe(o_wrStrobe)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (transaction level) ----------------
  logic [7:0]    m_regs [NR] = '{default: 8'h00};
  logic          m_resp_pending = 1'b0;   // a response byte is owed to the host
  logic [7:0]    m_resp = 8'h00;
  logic          m_want_data = 1'b0;      // a write command awaits its data byte
  logic [6:0]    m_addr = 7'h00;
  int            m_idle_cycles = 0;       // cycles spent waiting for write data
  logic [NR-1:0] m_strobe = '0;

  function automatic logic [7:0] m_read(input logic [6:0] a);
    if (a == 7'h7F) return 8'hA5;
    if (a == 7'h7E) return i_status;
    if (int'(a) < NR) return m_regs[int'(a)];
    return 8'h00;
  endfunction

  function automatic logic [63:0] m_flat();
    logic [63:0] f = 64'h0;
    for (int k = 0; k < NR; k++) f[8*k +: 8] = m_regs[k];
    return f;
  endfunction

  always @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < NR; k++) m_regs[k] = 8'h00;
      m_resp_pending = 1'b0; m_resp = 8'h00; m_want_data = 1'b0;
      m_idle_cycles = 0; m_strobe = '0;
    end else begin
      m_strobe = '0;
      if (m_resp_pending) begin
        if (i_devToHost_ready) m_resp_pending = 1'b0;
      end else if (i_hostToDev_valid) begin
        if (m_want_data) begin
          if (int'(m_addr) < NR) begin
            m_regs[int'(m_addr)] = i_hostToDev_data;
            m_strobe[int'(m_addr)] = 1'b1;
          end
          m_want_data = 1'b0;
        end else if (i_hostToDev_data[7]) begin
          m_want_data = 1'b1; m_addr = i_hostToDev_data[6:0]; m_idle_cycles = 0;
        end else begin
          m_resp = m_read(i_hostToDev_data[6:0]);
          m_resp_pending = 1'b1;
        end
      end else if (m_want_data) begin
        m_idle_cycles++;
        if (m_idle_cycles >= TMO) m_want_data = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge i_clk) begin
    check("ready",  {63'b0, o_hostToDev_ready}, {63'b0, !m_resp_pending});
    check("valid",  {63'b0, o_devToHost_valid}, {63'b0, m_resp_pending});
    if (m_resp_pending || !i_rst_n) check("data", {56'b0, o_devToHost_data}, {56'b0, m_resp});
    check("regs",   o_regs, m_flat());
    check("strobe", {56'b0, o_wrStrobe}, {56'b0, m_strobe});
  end

  // Present one byte upstream and hold it until accepted; returns 1 ns after the accepting edge.
  task automatic send_byte(input logic [7:0] b);
    logic r;
    int n;
    r = 1'b0; n = 0;
    i_hostToDev_valid = 1'b1;
    i_hostToDev_data  = b;
    do begin
      @(negedge i_clk); r = o_hostToDev_ready;
      @(posedge i_clk); n++;
    end while (!r && n < 100);
    check("send_accept", {63'b0, r}, 64'd1);
    #1 i_hostToDev_valid = 1'b0;
  endtask

  initial begin
    #1 i_rst_n = 1'b0;
    #12;
    check("rst_ready",  {63'b0, o_hostToDev_ready}, 64'd1);
    check("rst_valid",  {63'b0, o_devToHost_valid}, 64'd0);
    check("rst_data",   {56'b0, o_devToHost_data}, 64'd0);
    check("rst_regs",   o_regs, 64'd0);
    check("rst_strobe", {56'b0, o_wrStrobe}, 64'd0);
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Write reg3 = 0x5C, strobe bit3 for one cycle.
    send_byte(8'h83); send_byte(8'h5C);
    check("w3_strobe", {56'b0, o_wrStrobe}, 64'h08);
    check("w3_regs",   o_regs, 64'h0000_0000_5C00_0000);
    @(posedge i_clk); #1;
    check("w3_strobe_off", {56'b0, o_wrStrobe}, 64'h00);

    // Read reg3 with sink ready: one-cycle response.
    send_byte(8'h03);
    check("r3_valid", {63'b0, o_devToHost_valid}, 64'd1);
    check("r3_data",  {56'b0, o_devToHost_data}, 64'h5C);
    @(posedge i_clk); #1;
    check("r3_drop", {63'b0, o_devToHost_valid}, 64'd0);

    // Back-to-back write then read of the same register.
    send_byte(8'h85); send_byte(8'h9A); send_byte(8'h05);
    check("r5_data", {56'b0, o_devToHost_data}, 64'h9A);
    @(posedge i_clk); #1;

    // Read ID with sink stalled for 10 cycles; status read queued behind it.
    i_devToHost_ready = 1'b0;
    send_byte(8'h7F);
    fork
      send_byte(8'h7E);
      begin
        for (int i = 0; i < 10; i++) begin
          @(negedge i_clk);
          check("id_valid", {63'b0, o_devToHost_valid}, 64'd1);
          check("id_data",  {56'b0, o_devToHost_data}, 64'hA5);
          check("id_stall", {63'b0, o_hostToDev_ready}, 64'd0);
        end
        i_devToHost_ready = 1'b1;
      end
    join
    check("st_data", {56'b0, o_devToHost_data}, 64'h3C);
    @(posedge i_clk); #1;

    // Data byte arriving on the last cycle before timeout is still a write.
    send_byte(8'h82);
    repeat (15) @(posedge i_clk);
    #1 send_byte(8'h77);
    check("w2_strobe", {56'b0, o_wrStrobe}, 64'h04);

    // Write command with no data: abandoned after 16 cycles, next byte is a read.
    send_byte(8'h81);
    repeat (16) @(posedge i_clk);
    #1 send_byte(8'h01);
    check("tmo_valid", {63'b0, o_devToHost_valid}, 64'd1);
    check("tmo_data",  {56'b0, o_devToHost_data}, 64'h00);
    check("tmo_regs",  o_regs, 64'h0000_9A00_5C77_0000);
    @(posedge i_clk); #1;

    // Out-of-range write discarded, out-of-range read returns zero.
    send_byte(8'hC0); send_byte(8'hFF);
    check("oor_strobe", {56'b0, o_wrStrobe}, 64'h00);
    check("oor_regs",   o_regs, 64'h0000_9A00_5C77_0000);
    send_byte(8'h40);
    check("oor_rd", {56'b0, o_devToHost_data}, 64'h00);
    @(posedge i_clk); #1;

    // Asynchronous reset while a response is pending.
    i_devToHost_ready = 1'b0;
    send_byte(8'h02);
    check("r2_data", {56'b0, o_devToHost_data}, 64'h77);
    #2 i_rst_n = 1'b0;
    #1;
    check("arst_valid", {63'b0, o_devToHost_valid}, 64'd0);
    check("arst_data",  {56'b0, o_devToHost_data}, 64'h00);
    check("arst_ready", {63'b0, o_hostToDev_ready}, 64'd1);
    check("arst_regs",  o_regs, 64'h0);
    i_devToHost_ready = 1'b1;
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Asynchronous reset mid-write: next byte is a fresh command.
    send_byte(8'h84);
    #2 i_rst_n = 1'b0;
    #1 check("arst2_ready", {63'b0, o_hostToDev_ready}, 64'd1);
    @(negedge i_clk); #2 i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    send_byte(8'h55);
    check("post_rd55", {56'b0, o_devToHost_data}, 64'h00);
    check("post_regs", o_regs, 64'h0);
    send_byte(8'h00);
    check("post_rd0_valid", {63'b0, o_devToHost_valid}, 64'd1);
    check("post_rd0", {56'b0, o_devToHost_data}, 64'h00);
    repeat (3) @(posedge i_clk);
    #1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
